// File: rtl/guess_timer_pkg.sv
// guess_timer_pkg
//   Shared types and helpers for the round countdown timer.
//   - timer_state_t : round FSM states
//   - sat_add/sat_sub : clamp a signed result into [0, max_v]
//   - load_value : difficulty-dependent start time, saturated to the counter range
package guess_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSED,
    STOPPED,
    EXPIRED
  } timer_state_t;

  // Adds a signed delta and clamps the result into [0, max_v].
  function automatic int sat_add(int a, int b, int max_v);
    int s;
    s = a + b;
    if (s > max_v) return max_v;
    if (s < 0) return 0;
    return s;
  endfunction

  function automatic int sat_sub(int a, int b, int max_v);
    return sat_add(a, -b, max_v);
  endfunction

  // Out-of-range levels (0 or above num_levels) fall back to one step.
  function automatic int load_value(int level, int step_time, int num_levels, int cnt_w);
    int max_v;
    int prod;
    max_v = (1 << cnt_w) - 1;
    if (level >= 1 && level <= num_levels) prod = level * step_time;
    else prod = step_time;
    return (prod > max_v) ? max_v : prod;
  endfunction

endpackage

// File: rtl/guess_timer_if.sv
// guess_timer_if
//   Control and status bundle between the round controller and the timer.
//   Controller -> timer : start, stop, bonus (pulses), hold (level), max_digit
//   Timer -> controller : counter, running, expired, expire_pulse, warn
//   modport master : round controller side
//   modport slave  : timer side
interface guess_timer_if #(
  parameter int CNT_W = 7,
  parameter int LVL_W = 2
);
  import guess_timer_pkg::*;

  logic             start;
  logic             stop;
  logic             hold;
  logic             bonus;
  logic [LVL_W-1:0] max_digit;
  logic [CNT_W-1:0] counter;
  logic             running;
  logic             expired;
  logic             expire_pulse;
  logic             warn;

  modport master (
    output start, stop, hold, bonus, max_digit,
    input  counter, running, expired, expire_pulse, warn
  );

  modport slave (
    input  start, stop, hold, bonus, max_digit,
    output counter, running, expired, expire_pulse, warn
  );

endinterface

// File: rtl/guess_timer_tick_prescaler.sv
// tick_prescaler
//   Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
//   Ports:
//     clk     in  system clock
//     restart in  asynchronous active-low reset
//     clear   in  restart the count from 0 (wins over enable)
//     enable  in  count this cycle; count is frozen while low
//     tick    out high on the last enabled cycle of each period
module tick_prescaler
  import guess_timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic restart,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pres_q;
  logic [PW-1:0] pres_d;

  assign tick = enable && (pres_q == LAST);

  always_comb begin
    pres_d = pres_q;
    if (clear) pres_d = '0;
    else if (enable) pres_d = tick ? '0 : pres_q + 1'b1;
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) pres_q <= '0;
    else          pres_q <= pres_d;
  end

endmodule

// File: rtl/guess_timer.sv
// guess_timer
//   Round countdown timer for the number-guessing game. Loads a start time
//   from the difficulty level, counts down once per prescaled tick, supports
//   pause, stop-on-win and bonus time, and flags expiry and low time.
//   Ports:
//     clk     in  system clock
//     restart in  asynchronous active-low reset
//     bus     slave side of guess_timer_if (controls in, status out)
module guess_timer
  import guess_timer_pkg::*;
#(
  parameter int CNT_W      = 7,
  parameter int LVL_W      = 2,
  parameter int NUM_LEVELS = 3,
  parameter int STEP_TIME  = 30,
  parameter int TICK_DIV   = 50000000,
  parameter int BONUS_TIME = 5,
  parameter int WARN_TIME  = 10
) (
  input  logic           clk,
  input  logic           restart,
  guess_timer_if.slave   bus
);

  localparam int MAX_V = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] RESET_CNT =
    CNT_W'(load_value(1, STEP_TIME, NUM_LEVELS, CNT_W));

  timer_state_t     state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] load_cnt;
  logic             running_q, expired_q, pulse_q, warn_q;
  logic             running_d, expired_d, pulse_d, warn_d;
  logic             tick;

  assign load_cnt = CNT_W'(load_value(int'(bus.max_digit), STEP_TIME, NUM_LEVELS, CNT_W));

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .restart(restart),
    .clear  (bus.start),
    .enable ((state_q == RUN) && !bus.hold),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    if (bus.start) begin
      state_d   = RUN;
      counter_d = load_cnt;
    end else begin
      case (state_q)
        IDLE: counter_d = load_cnt;
        RUN, PAUSED: begin
          if (bus.stop) begin
            state_d = STOPPED;
          end else if (tick && !bus.bonus && counter_q == CNT_W'(1)) begin
            counter_d = '0;
            state_d   = EXPIRED;
          end else begin
            // A bonus on the final tick nets +BONUS_TIME-1 and rescues the round.
            if (bus.bonus)
              counter_d = CNT_W'(sat_add(int'(counter_q), BONUS_TIME - (tick ? 1 : 0), MAX_V));
            else if (tick)
              counter_d = CNT_W'(sat_sub(int'(counter_q), 1, MAX_V));
            state_d = bus.hold ? PAUSED : RUN;
          end
        end
        default: ;
      endcase
    end

    // Flags are computed from next state so they register alongside it.
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
    pulse_d   = (state_d == EXPIRED) && (state_q != EXPIRED);
    warn_d    = ((state_d == RUN) || (state_d == PAUSED)) &&
                (int'(counter_d) <= WARN_TIME);
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state_q   <= IDLE;
      counter_q <= RESET_CNT;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      warn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      running_q <= running_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      warn_q    <= warn_d;
    end
  end

  assign bus.counter      = counter_q;
  assign bus.running      = running_q;
  assign bus.expired      = expired_q;
  assign bus.expire_pulse = pulse_q;
  assign bus.warn         = warn_q;

endmodule

// File: tb/tb_guess_timer.sv
// tb_guess_timer
//   Directed scenarios with literal expectations, then randomized control
//   traffic, all checked every cycle against a behavioural model of the timer.
module tb_guess_timer;

  localparam int CNT_W      = 7;
  localparam int LVL_W      = 2;
  localparam int NUM_LEVELS = 3;
  localparam int STEP_TIME  = 30;
  localparam int TICK_DIV   = 4;
  localparam int BONUS_TIME = 5;
  localparam int WARN_TIME  = 10;
  localparam int MAXV       = (1 << CNT_W) - 1;

  // Model round phases (own numbering, independent of the design).
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_STOP = 3, M_EXP = 4;

  logic clk = 1'b0;
  logic restart = 1'b1;

  guess_timer_if #(.CNT_W(CNT_W), .LVL_W(LVL_W)) bus ();

  guess_timer #(
    .CNT_W(CNT_W), .LVL_W(LVL_W), .NUM_LEVELS(NUM_LEVELS), .STEP_TIME(STEP_TIME),
    .TICK_DIV(TICK_DIV), .BONUS_TIME(BONUS_TIME), .WARN_TIME(WARN_TIME)
  ) dut (
    .clk    (clk),
    .restart(restart),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mode = M_IDLE;
  int m_cnt  = STEP_TIME;
  int m_pres = 0;          // enabled cycles elapsed in the current tick period
  bit m_pulse = 1'b0;

  function automatic int clamp(int v);
    return (v > MAXV) ? MAXV : ((v < 0) ? 0 : v);
  endfunction

  function automatic int lv(int d);
    return (d >= 1 && d <= NUM_LEVELS) ? clamp(d * STEP_TIME) : clamp(STEP_TIME);
  endfunction

  task automatic model_step();
    int  prev_mode;
    int  delta;
    bit  tick;
    if (!restart) begin
      m_mode = M_IDLE; m_cnt = STEP_TIME; m_pres = 0; m_pulse = 1'b0;
    end else begin
      prev_mode = m_mode;
      tick = (m_mode == M_RUN) && !bus.hold && (m_pres == TICK_DIV - 1);
      if (m_mode == M_RUN && !bus.hold) m_pres = (m_pres + 1) % TICK_DIV;
      if (bus.start) begin
        m_mode = M_RUN; m_cnt = lv(int'(bus.max_digit)); m_pres = 0;
      end else if (m_mode == M_IDLE) begin
        m_cnt = lv(int'(bus.max_digit));
      end else if (m_mode == M_RUN || m_mode == M_PAUSED) begin
        if (bus.stop) m_mode = M_STOP;
        else if (tick && !bus.bonus && m_cnt == 1) begin
          m_cnt = 0; m_mode = M_EXP;
        end else begin
          delta  = (bus.bonus ? BONUS_TIME : 0) - (tick ? 1 : 0);
          m_cnt  = clamp(m_cnt + delta);
          m_mode = bus.hold ? M_PAUSED : M_RUN;
        end
      end
      m_pulse = (m_mode == M_EXP) && (prev_mode != M_EXP);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge restart);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("counter", int'(bus.counter), m_cnt);
      chk("running", int'(bus.running), int'(m_mode == M_RUN));
      chk("expired", int'(bus.expired), int'(m_mode == M_EXP));
      chk("expire_pulse", int'(bus.expire_pulse), int'(m_pulse));
      chk("warn", int'(bus.warn),
          int'((m_mode == M_RUN || m_mode == M_PAUSED) && m_cnt <= WARN_TIME));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
  endtask

  task automatic lit_flags(string tag, int cnt, int run, int exp, int pls, int wrn);
    chk({tag, "_counter"}, int'(bus.counter), cnt);
    chk({tag, "_running"}, int'(bus.running), run);
    chk({tag, "_expired"}, int'(bus.expired), exp);
    chk({tag, "_pulse"},   int'(bus.expire_pulse), pls);
    chk({tag, "_warn"},    int'(bus.warn), wrn);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.bonus = 0; bus.max_digit = '0;
    #3 restart = 1'b0;
    cyc(2);
    lit_flags("reset", 30, 0, 0, 0, 0);
    cmp_en = 1'b1;

    // Full countdown at level 2.
    restart = 1'b1; bus.max_digit = 2'd2;
    pulse_start();
    lit_flags("t1_load", 60, 1, 0, 0, 0);
    cyc(4);   chk("t1_first_tick", int'(bus.counter), 59);
    cyc(235); lit_flags("t1_last_sec", 1, 1, 0, 0, 1);
    cyc(1);   lit_flags("t1_expire", 0, 0, 1, 1, 0);
    cyc(1);   lit_flags("t1_after", 0, 0, 1, 0, 0);

    // IDLE preview and max_digit ignored mid-round.
    restart = 1'b0; cyc(1); restart = 1'b1; bus.max_digit = 2'd0;
    cyc(1); chk("t2_preview0", int'(bus.counter), 30);
    bus.max_digit = 2'd3;
    cyc(1); chk("t2_preview3", int'(bus.counter), 90);
    pulse_start();
    lit_flags("t2_load", 90, 1, 0, 0, 0);
    bus.max_digit = 2'd1;
    cyc(4); chk("t2_ignore_digit", int'(bus.counter), 89);

    // Pause at 12 with a partly-used prescaler period.
    cyc(308); chk("t3_at12", int'(bus.counter), 12);
    cyc(2);
    bus.hold = 1'b1; cyc(10);
    lit_flags("t3_paused", 12, 0, 0, 0, 0);
    bus.hold = 1'b0; cyc(2);
    lit_flags("t3_resumed", 12, 1, 0, 0, 0);
    cyc(1); chk("t3_tick_after_resume", int'(bus.counter), 11);
    cyc(4); lit_flags("t3_warn", 10, 1, 0, 0, 1);

    // Bonus on the final tick, then saturation while paused.
    cyc(36); chk("t4_at1", int'(bus.counter), 1);
    cyc(3);
    bus.bonus = 1'b1; cyc(1); bus.bonus = 1'b0;
    lit_flags("t4_rescue", 5, 1, 0, 0, 1);
    bus.hold = 1'b1; cyc(1);
    bus.bonus = 1'b1; cyc(24); bus.bonus = 1'b0;
    chk("t4_at125", int'(bus.counter), 125);
    bus.bonus = 1'b1; cyc(1); bus.bonus = 1'b0;
    chk("t4_saturate", int'(bus.counter), 127);

    // Stop on the final tick, bonus ignored, restart round.
    bus.hold = 1'b0; bus.max_digit = 2'd1;
    pulse_start(); chk("t5_load", int'(bus.counter), 30);
    cyc(116); chk("t5_at1", int'(bus.counter), 1);
    cyc(3);
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
    lit_flags("t5_stopped", 1, 0, 0, 0, 0);
    bus.bonus = 1'b1; cyc(1); bus.bonus = 1'b0;
    chk("t5_bonus_ignored", int'(bus.counter), 1);
    bus.max_digit = 2'd2;
    pulse_start(); lit_flags("t5_restart", 60, 1, 0, 0, 0);

    // Asynchronous reset between clock edges.
    cyc(7);
    @(posedge clk); #2 restart = 1'b0;
    #1 lit_flags("t6_async", 30, 0, 0, 0, 0);
    @(negedge clk); restart = 1'b1;
    cyc(1); lit_flags("t6_release", 60, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 299) == 0);
      bus.stop  = ($urandom_range(0, 399) == 0);
      bus.bonus = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) bus.hold = ~bus.hold;
      if ($urandom_range(0, 19) == 0) bus.max_digit = LVL_W'($urandom_range(0, 3));
      restart = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    bus.start = 0; bus.stop = 0; bus.bonus = 0; bus.hold = 0; restart = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_timer.md
Name: guess_timer

Overview:
Parametrised round countdown timer for the number-guessing game.
- Loads a difficulty-dependent start time from max_digit and decrements once per prescaled tick.
- Supports hold/pause, stop on a correct guess, and bonus-time add.
- Drives an expiry flag and a low-time warning flag for the round controller and the 7-segment display path.

Parameters:
CNT_W, 7, width of the counter output in seconds
LVL_W, 2, width of max_digit
NUM_LEVELS, 3, highest valid difficulty level
STEP_TIME, 30, seconds per difficulty level (load = level*STEP_TIME)
TICK_DIV, 50000000, clk cycles per timer tick (>=2)
BONUS_TIME, 5, seconds added per bonus pulse
WARN_TIME, 10, warn asserts when counter <= this in RUN or PAUSED

Ports:
clk  in  1  system clock
restart  in  1  asynchronous active-low reset
start  in  1  pulse; load start time and run
stop  in  1  pulse; freeze the counter (round won)
hold  in  1  level; pause the countdown while high
bonus  in  1  pulse; add BONUS_TIME
max_digit  in  LVL_W  difficulty select
counter  out  CNT_W  remaining seconds, registered
running  out  1  high in RUN
expired  out  1  level; high in EXPIRED
expire_pulse  out  1  one-cycle pulse on entry to EXPIRED
warn  out  1  low-time indicator

Behaviour:
- Reset (restart=0, async): state IDLE, prescaler 0, counter=STEP_TIME, running=0, expired=0, expire_pulse=0, warn=0.
- Load value L(d):
  - d in 1..NUM_LEVELS: d*STEP_TIME.
  - d=0 or d>NUM_LEVELS: STEP_TIME.
  - Computed at CNT_W+LVL_W bits, saturated to 2^CNT_W-1.
- States: IDLE, RUN, PAUSED, STOPPED, EXPIRED.
- IDLE:
  - counter <= L(max_digit) every cycle (1-cycle latency preview).
  - start -> RUN, counter <= L(max_digit), prescaler <= 0.
- start in any state: same action as from IDLE (round restart). expired and warn are re-evaluated from the new state.
- Priority per cycle: start > stop > (tick, bonus) > hold.
- Tick: prescaler counts only in RUN with hold=0, and freezes while hold=1. tick = (prescaler==TICK_DIV-1), after which the prescaler wraps to 0. First tick occurs TICK_DIV cycles after start.
- RUN:
  - stop -> STOPPED, counter frozen.
  - hold=1 -> PAUSED. No tick that cycle; prescaler frozen.
  - Tick without bonus: counter-1. If counter was 1, counter <= 0, EXPIRED, expire_pulse=1 next cycle.
  - Bonus without tick: counter+BONUS_TIME, saturating at 2^CNT_W-1.
  - Tick and bonus together: counter+BONUS_TIME-1, saturating. No expiry even if counter was 1.
- PAUSED:
  - hold=0 -> RUN, prescaler resumes from its held value.
  - Bonus is applied; stop -> STOPPED.
- STOPPED and EXPIRED:
  - counter held; bonus, hold and tick are ignored.
  - Exit only via start or restart.
- max_digit is sampled only at start (and previewed in IDLE). Changes during RUN, PAUSED, STOPPED or EXPIRED are ignored.
- The counter never wraps below 0 or above 2^CNT_W-1.
- running = (state==RUN). expired = (state==EXPIRED). warn = (state in RUN or PAUSED) && counter<=WARN_TIME. All outputs are registered.
- Reset mid-round returns to IDLE immediately; no partial-round state survives.

Decomposition:
- guess_timer_pkg:
  - timer_state_t enum (IDLE, RUN, PAUSED, STOPPED, EXPIRED).
  - Saturating add/sub helper functions.
  - load_value function parametrised by STEP_TIME, NUM_LEVELS and CNT_W.
- Sub-module tick_prescaler (TICK_DIV):
  - Inputs: clk, restart, clear, enable.
  - Output: tick.
  - Enable is low in every state except RUN with hold=0.
- All other logic (FSM, counter datapath, flags) lives in guess_timer.

Test Plan:
1. TICK_DIV=4, max_digit=2, pulse start -> counter=60 next cycle, running=1; after 4 cycles counter=59; after 240 cycles counter=0, expired=1, expire_pulse high for exactly 1 cycle, warn=0.
2. max_digit=0, then max_digit=3 while in IDLE -> counter previews 30, then 90 one cycle later; start loads 90. Changing max_digit to 1 mid-RUN leaves the countdown continuing from 90.
3. RUN at counter=12: hold high for 10 cycles -> state PAUSED, counter stays 12, warn=0. Release hold -> next tick arrives after the remaining prescaler count; at counter=10 warn=1.
4. Counter=1: bonus on the same cycle as the final tick -> counter=5, no expiry. Separately, with CNT_W=7 and counter=125, bonus -> counter=127 (saturated).
5. Stop and final tick on the same cycle at counter=1 -> STOPPED, counter=1, expired=0. A later bonus is ignored; start reloads L(max_digit) and returns to RUN.
6. Drive restart=0 asynchronously mid-RUN between clock edges -> outputs reach their reset values immediately. After release with max_digit=2, counter=60 on the first clock edge.
